// File: rtl/fifo_block_reader.sv
// Read-side master for a 1-cycle-latency FIFO: drains len words into a
// valid/ready stream through a 2-entry skid buffer, flags the last word, then pulses done.
module fifo_block_reader #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_empty,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] issued_r;
   logic [CNT_W-1:0] accepted_r;
   logic             busy_r;
   logic             done_r;
   logic [1:0]       occ_r;
   logic             inflight_r;
   logic [WIDTH-1:0] buf0_r;
   logic [WIDTH-1:0] buf1_r;

   logic             pop_s;
   logic             rd_en_s;
   logic             last_pop_s;
   logic [2:0]       occ_after_s;

   // Issue decision: a new read may only go out if the word it returns still fits.
   always_comb begin
      pop_s       = 1'b0;
      rd_en_s     = 1'b0;
      last_pop_s  = 1'b0;
      occ_after_s = 3'd0;
      if (occ_r != 2'd0) begin
         pop_s = m_ready;
      end else begin
         pop_s = 1'b0;
      end
      occ_after_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      if ((state_r == ST_XFER) && !fifo_empty && (issued_r < len_r) && (occ_after_s <= 3'd1)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
      if (pop_s && (accepted_r == (len_r - CNT_W'(1)))) begin
         last_pop_s = 1'b1;
      end else begin
         last_pop_s = 1'b0;
      end
   end

   // Transfer control: state, word counters and the busy/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         len_r      <= {CNT_W{1'b0}};
         issued_r   <= {CNT_W{1'b0}};
         accepted_r <= {CNT_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  len_r      <= len;
                  issued_r   <= {CNT_W{1'b0}};
                  accepted_r <= {CNT_W{1'b0}};
                  busy_r     <= 1'b1;
                  if (len == {CNT_W{1'b0}}) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_XFER;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_XFER: begin
               if (rd_en_s) begin
                  issued_r <= issued_r + CNT_W'(1);
               end
               if (pop_s) begin
                  accepted_r <= accepted_r + CNT_W'(1);
               end
               if (last_pop_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Skid buffer: pop shifts entry 1 to the head, the returning word lands at the new tail.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_r      <= 2'd0;
         inflight_r <= 1'b0;
         buf0_r     <= {WIDTH{1'b0}};
         buf1_r     <= {WIDTH{1'b0}};
      end else begin
         occ_r      <= occ_after_s[1:0];
         inflight_r <= rd_en_s;
         if (pop_s) begin
            if (occ_r == 2'd2) begin
               buf0_r <= buf1_r;
               if (inflight_r) begin
                  buf1_r <= fifo_dout;
               end
            end else if (inflight_r) begin
               buf0_r <= fifo_dout;
            end
         end else if (inflight_r) begin
            if (occ_r == 2'd0) begin
               buf0_r <= fifo_dout;
            end else begin
               buf1_r <= fifo_dout;
            end
         end
      end
   end

   assign fifo_rd_en = rd_en_s;
   assign busy       = busy_r;
   assign done       = done_r;
   assign m_valid    = (occ_r != 2'd0);
   assign m_data     = buf0_r;
   assign m_last     = (occ_r != 2'd0) && (accepted_r == (len_r - CNT_W'(1)));

endmodule
